// File: rtl/mac_tap_sequencer_if.sv
// mac_tap_sequencer_if: handshake and MAC-array signals of the tap sequencer.
// The ABORT wire exists only when MAC_SEQ_ABORT_EN is defined.
// master: job source / result sink / array side; slave: the sequencer itself.
interface mac_tap_sequencer_if #(
    parameter int TAP_W = 8
);
    logic             START;
    logic [TAP_W-1:0] NUM_TAPS;
    logic [31:0]      IN_OPER;
    logic [31:0]      IN_COEF;
    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      MAC_OPER_DATA;
    logic [31:0]      MAC_COEF_DATA;
    logic             MAC_ACC_CLEAR;
    logic             EFPGA_MATHB_CLK_EN;
    logic [31:0]      MAC0_OUT;
    logic [31:0]      RESULT;
    logic             RESULT_VALID;
    logic             RESULT_READY;
    logic             BUSY;
`ifdef MAC_SEQ_ABORT_EN
    logic             ABORT;

    modport master (
        output START, NUM_TAPS, IN_OPER, IN_COEF, IN_VALID, MAC0_OUT, RESULT_READY, ABORT,
        input  IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_CLEAR, EFPGA_MATHB_CLK_EN,
               RESULT, RESULT_VALID, BUSY
    );
    modport slave (
        input  START, NUM_TAPS, IN_OPER, IN_COEF, IN_VALID, MAC0_OUT, RESULT_READY, ABORT,
        output IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_CLEAR, EFPGA_MATHB_CLK_EN,
               RESULT, RESULT_VALID, BUSY
    );
`else
    modport master (
        output START, NUM_TAPS, IN_OPER, IN_COEF, IN_VALID, MAC0_OUT, RESULT_READY,
        input  IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_CLEAR, EFPGA_MATHB_CLK_EN,
               RESULT, RESULT_VALID, BUSY
    );
    modport slave (
        input  START, NUM_TAPS, IN_OPER, IN_COEF, IN_VALID, MAC0_OUT, RESULT_READY,
        output IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, MAC_ACC_CLEAR, EFPGA_MATHB_CLK_EN,
               RESULT, RESULT_VALID, BUSY
    );
`endif
endinterface

// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: feeds operand/coefficient pairs to the MAC array for an
// N-tap dot product, waits out the accumulator latency and presents the
// captured 32-bit result on a valid/ready port.
// Optional: define MAC_SEQ_ABORT_EN to add the ABORT input.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | accepting pairs, one clock-enable pulse per accepted pair
// DRAIN | waiting MAC_LAT cycles for the array to settle after the last tap
// DONE  | RESULT_VALID held until RESULT_READY
module mac_tap_sequencer #(
    parameter int TAP_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic               MAC_ACC_CLK,
    input  logic               MAC_ACC_RST,
    mac_tap_sequencer_if.slave bus
);
    localparam int DRN_W = $clog2(MAC_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic             first_q, first_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [31:0]      oper_q, oper_d;
    logic [31:0]      coef_q, coef_d;
    logic [31:0]      result_q, result_d;
    logic             clken_q, clken_d;
    logic             clear_q, clear_d;
    logic             in_ready_q, in_ready_d;
    logic             rvalid_q, rvalid_d;
    logic             busy_q, busy_d;
    logic             abort_w;
    logic             xfer_w;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_w = bus.ABORT;
`else
    assign abort_w = 1'b0;
`endif

    // IN_READY is registered and high exactly while in RUN
    assign xfer_w = bus.IN_VALID && in_ready_q;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        first_d  = first_q;
        drain_d  = drain_q;
        oper_d   = oper_q;
        coef_d   = coef_q;
        result_d = result_q;
        clken_d  = 1'b0;
        clear_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    taps_d  = bus.NUM_TAPS;
                    first_d = 1'b1;
                    if (bus.NUM_TAPS == '0) begin
                        result_d = 32'd0;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    // A pair accepted on this edge is swallowed, never issued
                    state_d = S_IDLE;
                end else if (xfer_w) begin
                    oper_d  = bus.IN_OPER;
                    coef_d  = bus.IN_COEF;
                    clken_d = 1'b1;
                    clear_d = first_q;
                    first_d = 1'b0;
                    taps_d  = taps_q - TAP_W'(1);
                    if (taps_q == TAP_W'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = DRN_W'(MAC_LAT);
                    end
                end
            end
            S_DRAIN: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (drain_q == '0) begin
                    result_d = bus.MAC0_OUT;
                    state_d  = S_DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: begin
                if (bus.RESULT_READY) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        in_ready_d = (state_d == S_RUN);
        rvalid_d   = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge MAC_ACC_CLK) begin
        if (MAC_ACC_RST) begin
            state_q    <= S_IDLE;
            taps_q     <= '0;
            first_q    <= 1'b0;
            drain_q    <= '0;
            oper_q     <= '0;
            coef_q     <= '0;
            result_q   <= '0;
            clken_q    <= 1'b0;
            clear_q    <= 1'b0;
            in_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            taps_q     <= taps_d;
            first_q    <= first_d;
            drain_q    <= drain_d;
            oper_q     <= oper_d;
            coef_q     <= coef_d;
            result_q   <= result_d;
            clken_q    <= clken_d;
            clear_q    <= clear_d;
            in_ready_q <= in_ready_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.IN_READY           = in_ready_q;
    assign bus.MAC_OPER_DATA      = oper_q;
    assign bus.MAC_COEF_DATA      = coef_q;
    assign bus.MAC_ACC_CLEAR      = clear_q;
    assign bus.EFPGA_MATHB_CLK_EN = clken_q;
    assign bus.RESULT             = result_q;
    assign bus.RESULT_VALID       = rvalid_q;
    assign bus.BUSY               = busy_q;
endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb_mac_tap_sequencer: random and directed jobs against a dot-product model;
// a behavioural MAC array closes the loop on MAC0_OUT.
module tb_mac_tap_sequencer;
    localparam int TAP_W   = 8;
    localparam int MAC_LAT = 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   en_cnt;
    int   clr_cnt;
    logic [31:0] q_op[$];
    logic [31:0] q_cf[$];
    logic [31:0] last_res;

    mac_tap_sequencer_if #(.TAP_W(TAP_W)) bus ();

    mac_tap_sequencer #(.TAP_W(TAP_W), .MAC_LAT(MAC_LAT)) dut (
        .MAC_ACC_CLK (clk),
        .MAC_ACC_RST (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: accumulate on clock enable, output delayed to MAC_LAT
    logic [31:0] arr_pipe [MAC_LAT];
    always @(posedge clk) begin
        if (bus.EFPGA_MATHB_CLK_EN)
            arr_pipe[0] <= bus.MAC_ACC_CLEAR ? bus.MAC_OPER_DATA * bus.MAC_COEF_DATA
                                             : arr_pipe[0] + bus.MAC_OPER_DATA * bus.MAC_COEF_DATA;
        for (int j = 1; j < MAC_LAT; j++) arr_pipe[j] <= arr_pipe[j-1];
    end
    assign bus.MAC0_OUT = arr_pipe[MAC_LAT-1];

    // Count enable and clear cycles seen on the array side
    always @(negedge clk) begin
        if (bus.EFPGA_MATHB_CLK_EN) en_cnt <= en_cnt + 1;
        if (bus.MAC_ACC_CLEAR) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, bus.IN_READY, bus.MAC_ACC_CLEAR, bus.EFPGA_MATHB_CLK_EN,
                            bus.RESULT_VALID, bus.BUSY}, 32'd0);
        chk({tag, "_oper"}, bus.MAC_OPER_DATA, 32'd0);
        chk({tag, "_coef"}, bus.MAC_COEF_DATA, 32'd0);
        chk({tag, "_res"}, bus.RESULT, 32'd0);
    endtask

    // One full job starting at a negedge; pairs come from q_op/q_cf when queued
    task automatic run_job(input int ntaps, input int stall_at, input int stall_len, input int hold);
        logic [31:0] exp_sum, op, cf, last_op;
        int en0, cl0, wait_n;
        exp_sum = 32'd0;
        last_op = bus.MAC_OPER_DATA;
        en0 = en_cnt;
        cl0 = clr_cnt;
        bus.START    = 1'b1;
        bus.NUM_TAPS = ntaps[TAP_W-1:0];
        @(negedge clk);
        bus.START = 1'b0;
        chk("busy_rise", {31'd0, bus.BUSY}, 32'd1);
        if (ntaps == 0) begin
            chk("zero_valid", {31'd0, bus.RESULT_VALID}, 32'd1);
            chk("zero_en", en_cnt - en0, 32'd0);
        end else begin
            chk("in_ready", {31'd0, bus.IN_READY}, 32'd1);
            for (int i = 0; i < ntaps; i++) begin
                if (i == stall_at) begin
                    bus.IN_VALID = 1'b0;
                    bus.IN_OPER  = $urandom;
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk);
                        chk("stall_en", {31'd0, bus.EFPGA_MATHB_CLK_EN}, 32'd0);
                        chk("stall_hold", bus.MAC_OPER_DATA, last_op);
                    end
                end
                if (q_op.size() > 0) begin
                    op = q_op.pop_front();
                    cf = q_cf.pop_front();
                end else begin
                    op = $urandom;
                    cf = $urandom;
                end
                bus.IN_VALID = 1'b1;
                bus.IN_OPER  = op;
                bus.IN_COEF  = cf;
                @(negedge clk);
                chk("oper", bus.MAC_OPER_DATA, op);
                chk("coef", bus.MAC_COEF_DATA, cf);
                chk("clk_en", {31'd0, bus.EFPGA_MATHB_CLK_EN}, 32'd1);
                chk("clear", {31'd0, bus.MAC_ACC_CLEAR}, (i == 0) ? 32'd1 : 32'd0);
                exp_sum = exp_sum + op * cf;
                last_op = op;
            end
            bus.IN_VALID = 1'b0;
            wait_n = 0;
            while (!bus.RESULT_VALID && wait_n < MAC_LAT + 20) begin
                @(negedge clk);
                wait_n++;
            end
            chk("latency", wait_n, MAC_LAT + 1);
            chk("en_count", en_cnt - en0, ntaps);
            chk("clr_count", clr_cnt - cl0, 32'd1);
        end
        chk("result", bus.RESULT, exp_sum);
        for (int h = 0; h < hold; h++) begin
            bus.START    = (h == hold / 2);
            bus.NUM_TAPS = TAP_W'($urandom_range(1, 5));
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.RESULT_VALID}, 32'd1);
            chk("hold_result", bus.RESULT, exp_sum);
        end
        bus.START        = 1'b0;
        bus.RESULT_READY = 1'b1;
        last_res         = bus.RESULT;
        @(negedge clk);
        bus.RESULT_READY = 1'b0;
        chk("rv_drop", {31'd0, bus.RESULT_VALID}, 32'd0);
        chk("busy_drop", {31'd0, bus.BUSY}, 32'd0);
        chk("idle_ready", {31'd0, bus.IN_READY}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, sa, en1;
        n_chk = 0;
        n_err = 0;
        en_cnt = 0;
        clr_cnt = 0;
        rst = 1'b1;
        bus.START = 1'b0;
        bus.NUM_TAPS = '0;
        bus.IN_OPER = '0;
        bus.IN_COEF = '0;
        bus.IN_VALID = 1'b0;
        bus.RESULT_READY = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        bus.ABORT = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed dot product 2*3 + 4*5 + 6*7
        q_op = '{32'd2, 32'd4, 32'd6};
        q_cf = '{32'd3, 32'd5, 32'd7};
        run_job(3, -1, 0, 1);
        chk("dot68", last_res, 32'd68);

        run_job(0, -1, 0, 2);
        run_job(4, 2, 3, 1);
        run_job(2, -1, 0, 10);
        run_job(255, 100, 2, 0);

        // Reset in the middle of a 5-tap job
        bus.START = 1'b1;
        bus.NUM_TAPS = TAP_W'(5);
        @(negedge clk);
        bus.START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_OPER = $urandom;
            bus.IN_COEF = $urandom;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        bus.IN_VALID = 1'b0;
        en1 = en_cnt;
        repeat (4) @(negedge clk);
        chk("rst_no_en", en_cnt - en1, 32'd0);
        chk("rst_idle", {31'd0, bus.BUSY}, 32'd0);
        q_op = '{32'd9};
        q_cf = '{32'd9};
        run_job(1, -1, 0, 0);
        chk("dot81", last_res, 32'd81);

`ifdef MAC_SEQ_ABORT_EN
        // Abort together with the second of four taps
        en1 = en_cnt;
        bus.START = 1'b1;
        bus.NUM_TAPS = TAP_W'(4);
        @(negedge clk);
        bus.START = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_OPER = 32'd11;
        bus.IN_COEF = 32'd12;
        @(negedge clk);
        bus.IN_OPER = 32'd13;
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("abort_en", {31'd0, bus.EFPGA_MATHB_CLK_EN}, 32'd0);
        chk("abort_ready", {31'd0, bus.IN_READY}, 32'd0);
        chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_rv", {31'd0, bus.RESULT_VALID}, 32'd0);
        end
        chk("abort_en_cnt", en_cnt - en1, 32'd1);
        // Abort held in IDLE does not block a job
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        bus.NUM_TAPS = TAP_W'(2);
        @(negedge clk);
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        chk("abort_idle_busy", {31'd0, bus.BUSY}, 32'd1);
        bus.IN_VALID = 1'b1;
        repeat (2) @(negedge clk);
        bus.IN_VALID = 1'b0;
        repeat (MAC_LAT + 1) @(negedge clk);
        chk("abort_idle_rv", {31'd0, bus.RESULT_VALID}, 32'd1);
        bus.RESULT_READY = 1'b1;
        @(negedge clk);
        bus.RESULT_READY = 1'b0;
`endif

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            nt = $urandom_range(0, 9);
            sa = (nt >= 2) ? $urandom_range(1, nt - 1) : -1;
            run_job(nt, sa, $urandom_range(1, 4), $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
